// File: rtl/seg_pkg.sv
// seg_pkg: shared seven-segment definitions for the display encoder and the
// capture monitor.
//   SEG_HEX   - active-low ABCDEFG codes for hex digits 0..F (bit 6 = A, bit 0 = G)
//   SEG_BLANK - all segments off
//   state_t   - capture FSM states
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HOLD
  } state_t;

endpackage

// File: rtl/seg2hex.sv
// seg2hex: combinational decode of an active-low ABCDEFG pattern.
// Ports:
//   pattern  in   7  segment pattern, active low
//   code     out  4  hex value when is_hex is set, otherwise 0
//   is_hex   out  1  pattern is one of the 16 hex codes
//   is_blank out  1  pattern has all segments off
module seg2hex
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    code   = '0;
    is_hex = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (pattern == SEG_HEX[i]) begin
        code   = 4'(i);
        is_hex = 1'b1;
      end
    end
    is_blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seg_display_capture.sv
// seg_display_capture: monitors the multiplexed 7-segment display drive,
// debounces each scan slot and records the hex value shown on every digit.
// Parameters:
//   NUM_DIGITS    number of anode enables / captured digits
//   STABLE_CYCLES consecutive identical samples required before a capture (>= 1)
// Ports:
//   clk      in   1             system clock, rising edge
//   reset    in   1             synchronous active-high reset
//   segment  in   7             ABCDEFG pattern, active low
//   digit    in   NUM_DIGITS    anode enables, active low
//   values   out  4*NUM_DIGITS  captured hex nibble per digit
//   valid    out  NUM_DIGITS    digit last captured a hex pattern
//   blank    out  NUM_DIGITS    digit last captured all segments off
//   bad      out  NUM_DIGITS    digit last captured an unrecognised pattern
//   update   out  1             one-cycle pulse per capture
//   frame    out  1             one-cycle pulse when all digits have been captured
// Optional feature (macro SEG_CAPTURE_DP_EN):
//   dp       in   1             decimal point, active low
//   dp_vals  out  NUM_DIGITS    decimal point state captured per digit
module seg_display_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              segment,
  input  logic [NUM_DIGITS-1:0]   digit,
  output logic [4*NUM_DIGITS-1:0] values,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   bad,
  output logic                    update,
  output logic                    frame
`ifdef SEG_CAPTURE_DP_EN
  ,
  input  logic                    dp,
  output logic [NUM_DIGITS-1:0]   dp_vals
`endif
);

  import seg_pkg::*;

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] dig_q, dig_p;
`ifdef SEG_CAPTURE_DP_EN
  logic                  dp_q, dp_p;
`endif

  state_t                state;
  logic [CW-1:0]         count;
  logic [CW-1:0]         cnt_next;
  logic [CW-1:0]         cnt_inc;
  logic                  do_cap;
  logic                  onehot;
  logic                  same;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_next;

  logic [3:0]            code;
  logic                  is_hex;
  logic                  is_blank;

  // Input stage; reset values are a non-selecting sample so that a full
  // stability window is needed again after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= SEG_BLANK;
      seg_p <= SEG_BLANK;
      dig_q <= '1;
      dig_p <= '1;
`ifdef SEG_CAPTURE_DP_EN
      dp_q  <= 1'b1;
      dp_p  <= 1'b1;
`endif
    end else begin
      seg_q <= segment;
      seg_p <= seg_q;
      dig_q <= digit;
      dig_p <= dig_q;
`ifdef SEG_CAPTURE_DP_EN
      dp_q  <= dp;
      dp_p  <= dp_q;
`endif
    end
  end

  seg2hex u_seg2hex (
    .pattern  (seg_q),
    .code     (code),
    .is_hex   (is_hex),
    .is_blank (is_blank)
  );

  assign sel       = ~dig_q;
  assign onehot    = $onehot(sel);
  assign seen_next = seen | sel;
  assign cnt_inc   = count + CW'(1);

`ifdef SEG_CAPTURE_DP_EN
  assign same = (seg_q == seg_p) && (dig_q == dig_p) && (dp_q == dp_p);
`else
  assign same = (seg_q == seg_p) && (dig_q == dig_p);
`endif

  // Count/capture decision. Entering from IDLE always starts a fresh window
  // at 1, so an equal sample straddling a reset or an idle gap never counts
  // twice. HOLD keeps count at STABLE_CYCLES so no second capture occurs.
  always_comb begin
    cnt_next = count;
    do_cap   = 1'b0;
    if (!onehot) begin
      cnt_next = '0;
    end else if (state == IDLE || !same) begin
      cnt_next = CW'(1);
      do_cap   = (STABLE_CYCLES == 1);
    end else if (state == TRACK) begin
      cnt_next = cnt_inc;
      do_cap   = (cnt_inc == CW'(STABLE_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      values  <= '0;
      valid   <= '0;
      blank   <= '0;
      bad     <= '0;
      update  <= 1'b0;
      frame   <= 1'b0;
      seen    <= '0;
`ifdef SEG_CAPTURE_DP_EN
      dp_vals <= '0;
`endif
    end else begin
      update <= 1'b0;
      frame  <= 1'b0;
      count  <= cnt_next;

      if (!onehot) begin
        state <= IDLE;
      end else if (do_cap) begin
        state <= HOLD;
      end else if (state == IDLE || !same) begin
        state <= TRACK;
      end

      if (do_cap) begin
        update <= 1'b1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            if (is_hex) begin
              values[4*i +: 4] <= code;
            end
            valid[i] <= is_hex;
            blank[i] <= is_blank;
            bad[i]   <= !is_hex && !is_blank;
`ifdef SEG_CAPTURE_DP_EN
            dp_vals[i] <= ~dp_q;
`endif
          end
        end
        if (&seen_next) begin
          frame <= 1'b1;
          seen  <= '0;
        end else begin
          seen  <= seen_next;
        end
      end
    end
  end

endmodule
